gps_carr_nco: RTL

GPS_CARR_NCO -- requirements
Module: gps_carr_nco

---
 rtl/gps_carr_nco.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gps_carr_nco.sv
// Carrier NCO: a phase accumulator drives a sin/cos lookup table and counts carrier cycles.
// Latency: 2 cycles from send_en to out_valid. Frequency changes are deferred to an accumulator wrap.
// Backpressure: none; send_en is a free-running strobe and every strobe yields one sample.
//
// Ports:
//   clk, rst          : clock; synchronous active-low reset
//   send_en           : sample strobe (advances the accumulator, launches one sample)
//   fcw_in, fcw_load  : frequency control word and its single-cycle load request
//   phase_off         : static phase offset in LUT steps
//   phase_clr         : zero the accumulator (wins over send_en)
//   fcw_pending       : a loaded FCW is waiting for the next wrap
//   carrierWave_sin/cos, out_valid : signed samples and their valid flag
//   carr_cycles       : count of accumulator wraps
module gps_carr_nco #(
    parameter int ACC_W = 32,
    parameter int LUT_W = 4,
    parameter int AMP_W = 12,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    send_en,
    input  logic [ACC_W-1:0]        fcw_in,
    input  logic                    fcw_load,
    input  logic [LUT_W-1:0]        phase_off,
    input  logic                    phase_clr,
    output logic                    fcw_pending,
    output logic signed [AMP_W-1:0] carrierWave_sin,
    output logic signed [AMP_W-1:0] carrierWave_cos,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        carr_cycles
);

    localparam int     N     = 2 ** LUT_W;
    localparam int     Q     = N / 4;
    // pi in Q28 fixed point, used only while building the tables
    localparam longint PI_Q  = 64'sd843314857;
    localparam longint AMP_A = (64'sd1 <<< (AMP_W - 1)) - 64'sd1;

    // Magnitude of A*sin(2*pi*j/N) for j in the first quadrant (0..Q), rounded.
    // Taylor series in Q28 fixed point; accurate far beyond one output LSB.
    function automatic longint quarter_sin(input int j);
        longint x;
        longint term;
        longint sum;
        x    = (64'sd2 * PI_Q * longint'(j)) / longint'(N);
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((((term * x) >>> 28) * x) >>> 28) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return (sum * AMP_A + (64'sd1 <<< 27)) >>> 28;
    endfunction

    // Full-cycle entry built from quadrant symmetry so negative codes are exact negatives.
    function automatic logic signed [AMP_W-1:0] sin_entry(input int k);
        int     qd;
        int     r;
        longint m;
        qd = k / Q;
        r  = k % Q;
        m  = (qd == 0 || qd == 2) ? quarter_sin(r) : quarter_sin(Q - r);
        if (qd >= 2) begin
            m = -m;
        end
        return AMP_W'(m);
    endfunction

    // Packed table; shift = Q turns the sine table into the cosine table.
    function automatic logic [N*AMP_W-1:0] build_tab(input int shift);
        logic [N*AMP_W-1:0] tab;
        tab = '0;
        for (int k = 0; k < N; k++) begin
            tab[k*AMP_W +: AMP_W] = sin_entry((k + shift) % N);
        end
        return tab;
    endfunction

    localparam logic [N*AMP_W-1:0] SIN_TAB = build_tab(0);
    localparam logic [N*AMP_W-1:0] COS_TAB = build_tab(Q);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] fcw_act;
    logic [ACC_W-1:0] fcw_shadow;
    logic [ACC_W:0]   acc_sum;
    logic             wrap;
    logic [LUT_W-1:0] idx;
    logic [LUT_W-1:0] idx_q;
    logic             vld_q;

    assign acc_sum = {1'b0, acc} + {1'b0, fcw_act};
    // A cleared accumulator never counts as a wrap, even when send_en is high.
    assign wrap    = send_en & ~phase_clr & acc_sum[ACC_W];
    // Index comes from the accumulator value before this cycle's update.
    assign idx     = acc[ACC_W-1 -: LUT_W] + phase_off;

    // Accumulator, frequency control and carrier cycle counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= '0;
            fcw_act     <= '0;
            fcw_shadow  <= '0;
            fcw_pending <= 1'b0;
            carr_cycles <= '0;
        end else begin
            if (phase_clr) begin
                acc <= '0;
            end else if (send_en) begin
                acc <= acc_sum[ACC_W-1:0];
            end

            if (wrap) begin
                carr_cycles <= carr_cycles + 1'b1;
            end

            if (fcw_load && !send_en) begin
                // Idle carrier: no phase to protect, apply immediately.
                fcw_act     <= fcw_in;
                fcw_shadow  <= fcw_in;
                fcw_pending <= 1'b0;
            end else begin
                // The wrap commits whatever was pending before this cycle;
                // a load in the same cycle waits for the following wrap.
                if (wrap && fcw_pending) begin
                    fcw_act <= fcw_shadow;
                end
                if (fcw_load) begin
                    fcw_shadow  <= fcw_in;
                    fcw_pending <= 1'b1;
                end else if (wrap) begin
                    fcw_pending <= 1'b0;
                end
            end
        end
    end

    // Two-stage sample pipeline; phase_clr does not flush it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q           <= '0;
            vld_q           <= 1'b0;
            out_valid       <= 1'b0;
            carrierWave_sin <= '0;
            carrierWave_cos <= '0;
        end else begin
            vld_q     <= send_en;
            idx_q     <= send_en ? idx : idx_q;
            out_valid <= vld_q;
            if (vld_q) begin
                carrierWave_sin <= SIN_TAB[int'(idx_q)*AMP_W +: AMP_W];
                carrierWave_cos <= COS_TAB[int'(idx_q)*AMP_W +: AMP_W];
            end
        end
    end

endmodule
